// File: rtl/audio_codec_config.sv
// WM8731-class codec configurator: replays a fixed init table (or one host write)
// over a write-only I2C master built from four-quarter bit slots.
module audio_codec_config #(
   parameter int unsigned CLK_FREQ = 50_000_000,
   parameter int unsigned I2C_FREQ = 100_000,
   parameter logic [6:0]  DEV_ADDR = 7'h1A,
   parameter int unsigned NUM_REGS = 11
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       wr_req,
   input  logic [6:0] wr_reg,
   input  logic [8:0] wr_data,
   output logic       busy,
   output logic       done,
   output logic       ack_error,
   output logic [3:0] err_index,
   output logic       i2c_sclk,
   output logic       i2c_sdat_oe,
   input  logic       i2c_sdat_in
);

   localparam int unsigned QTR      = CLK_FREQ / (4 * I2C_FREQ);
   localparam int unsigned DIV_W    = (QTR > 1) ? $clog2(QTR) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(QTR - 1);
   localparam logic [3:0]  IDX_LAST = 4'(NUM_REGS - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_BIT, S_ACK, S_STOP, S_GAP, S_FINISH
   } state_e;

   function automatic logic [15:0] init_word(input logic [3:0] idx);
      case (idx)
         4'd0:    return 16'h1E00;
         4'd1:    return 16'h0017;
         4'd2:    return 16'h0217;
         4'd3:    return 16'h0479;
         4'd4:    return 16'h0679;
         4'd5:    return 16'h0812;
         4'd6:    return 16'h0A06;
         4'd7:    return 16'h0C00;
         4'd8:    return 16'h0E42;
         4'd9:    return 16'h1000;
         4'd10:   return 16'h1201;
         default: return 16'h0000;
      endcase
   endfunction

   state_e           state_q, state_d;
   logic [DIV_W-1:0] div_q;
   logic [1:0]       qtr_q;
   logic [4:0]       bit_cnt_q;
   logic [3:0]       idx_q;
   logic             single_q;
   logic [15:0]      wr_word_q;
   logic             ack_error_q;
   logic [3:0]       err_index_q;

   logic        busy_w, tick, slot_end, accept, nack_now, frame_bit;
   logic [23:0] frame;

   assign busy_w    = (state_q != S_IDLE) && (state_q != S_FINISH);
   assign tick      = busy_w && (div_q == DIV_LAST);
   assign slot_end  = tick && (qtr_q == 2'd3);
   assign accept    = (state_q == S_IDLE) && (start || wr_req);
   assign frame     = {DEV_ADDR, 1'b0, (single_q ? wr_word_q : init_word(idx_q))};
   assign frame_bit = frame[bit_cnt_q];
   assign nack_now  = (state_q == S_ACK) && tick && (qtr_q == 2'd2) && i2c_sdat_in;

   always_ff @(posedge clk) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // bit_cnt_q walks the 24-bit frame 23..0; it stays on a byte's last bit through
   // the ACK slot, and is reused as the slot counter while in GAP.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (accept) state_d = S_START;
         S_START:  if (slot_end) state_d = S_BIT;
         S_BIT:    if (slot_end && bit_cnt_q[2:0] == 3'd0) state_d = S_ACK;
         S_ACK:    if (slot_end) state_d = (ack_error_q || bit_cnt_q == 5'd0) ? S_STOP : S_BIT;
         S_STOP:   if (slot_end) state_d = ack_error_q ? S_FINISH : S_GAP;
         S_GAP:    if (slot_end && bit_cnt_q == 5'd0)
                      state_d = (single_q || idx_q == IDX_LAST) ? S_FINISH : S_START;
         S_FINISH: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         div_q       <= '0;
         qtr_q       <= 2'd0;
         bit_cnt_q   <= 5'd0;
         idx_q       <= 4'd0;
         single_q    <= 1'b0;
         wr_word_q   <= 16'h0000;
         ack_error_q <= 1'b0;
         err_index_q <= 4'd0;
      end else begin
         div_q <= (busy_w && !tick) ? div_q + DIV_W'(1) : '0;
         if (!busy_w)   qtr_q <= 2'd0;
         else if (tick) qtr_q <= qtr_q + 2'd1;

         case (state_q)
            S_IDLE: if (accept) begin
               single_q    <= !start;
               wr_word_q   <= {wr_reg, wr_data};
               idx_q       <= 4'd0;
               ack_error_q <= 1'b0;
               err_index_q <= 4'd0;
            end
            S_START: if (slot_end) bit_cnt_q <= 5'd23;
            S_BIT:   if (slot_end && bit_cnt_q[2:0] != 3'd0) bit_cnt_q <= bit_cnt_q - 5'd1;
            S_ACK: begin
               if (nack_now) begin
                  ack_error_q <= 1'b1;
                  err_index_q <= single_q ? 4'd0 : idx_q;
               end
               if (slot_end && !ack_error_q && bit_cnt_q != 5'd0) bit_cnt_q <= bit_cnt_q - 5'd1;
            end
            S_STOP: if (slot_end) bit_cnt_q <= 5'd3;
            S_GAP: if (slot_end) begin
               if (bit_cnt_q != 5'd0)                   bit_cnt_q <= bit_cnt_q - 5'd1;
               else if (!single_q && idx_q != IDX_LAST) idx_q     <= idx_q + 4'd1;
            end
            default: ;
         endcase
      end
   end

   // NOTE: bus lines are decoded from registered state, so a synchronous reset
   // returns them to idle on the very next clock without a STOP.
   always_comb begin
      busy        = busy_w;
      done        = (state_q == S_FINISH);
      i2c_sclk    = 1'b1;
      i2c_sdat_oe = 1'b0;
      case (state_q)
         S_START: begin
            i2c_sclk    = (qtr_q != 2'd3);
            i2c_sdat_oe = qtr_q[1];
         end
         S_BIT: begin
            i2c_sclk    = (qtr_q == 2'd1) || (qtr_q == 2'd2);
            i2c_sdat_oe = !frame_bit;
         end
         S_ACK:   i2c_sclk = (qtr_q == 2'd1) || (qtr_q == 2'd2);
         S_STOP: begin
            i2c_sclk    = (qtr_q != 2'd0);
            i2c_sdat_oe = !qtr_q[1];
         end
         default: ;
      endcase
   end

   assign ack_error = ack_error_q;
   assign err_index = err_index_q;

endmodule
